// File: rtl/fsk_pll_scheduler_pkg.sv
// Shared definitions for the FSK PLL scheduler: state encodings, default
// timing constants and small field-sanitising helpers.
package fsk_pll_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SELECT    = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_EMIT      = 3'd3,
    S_GUARD     = 3'd4,
    S_FINISH    = 3'd5
  } fsk_state_e;

  localparam int FSK_NBITS_DEF        = 128;
  localparam int FSK_LOCK_TIMEOUT_DEF = 1200;  // 100 us at 12 MHz
  localparam int FSK_GUARD_CYCLES_DEF = 12;

  // A zero symbol time means "shortest symbol", not "no symbol".
  function automatic logic [15:0] min1_16(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

  // A zero repetition factor means "send once".
  function automatic logic [3:0] min1_4(input logic [3:0] v);
    return (v == 4'd0) ? 4'd1 : v;
  endfunction

endpackage

// File: rtl/fsk_pll_scheduler_lock_sync.sv
// Two-flop synchronizer for an asynchronous PLL LOCKED signal.
module fsk_pll_scheduler_lock_sync (
  input  logic clk_12mhz_int,
  input  logic M_RESET_B,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Double-register the async input; cleared to "not locked" in reset.
  always_ff @(posedge clk_12mhz_int or negedge M_RESET_B) begin
    if (!M_RESET_B) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/fsk_pll_scheduler.sv
// FSK PLL scheduler: releases only the PLL for the current bit, waits for its
// lock, gates the antenna for each symbol and walks the frame MSB first.
module fsk_pll_scheduler
  import fsk_pll_scheduler_pkg::*;
#(
  parameter int NBITS        = FSK_NBITS_DEF,
  parameter int LOCK_TIMEOUT = FSK_LOCK_TIMEOUT_DEF,
  parameter int GUARD_CYCLES = FSK_GUARD_CYCLES_DEF,
  localparam int BI_W        = $clog2(NBITS)
) (
  input  logic             clk_12mhz_int,
  input  logic             M_RESET_B,
  input  logic             i_frame_valid,
  output logic             o_frame_ready,
  input  logic [NBITS-1:0] i_frame_bits,
  input  logic [15:0]      i_symbol_time,
  input  logic [3:0]       i_rep_factor,
  input  logic             i_abort,
  input  logic             i_pll_888_locked,
  input  logic             i_pll_936_locked,
  output logic             o_pll_888_rst,
  output logic             o_pll_936_rst,
  output logic             o_freq_select,
  output logic             o_wave_enable,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_lock_err,
  output logic [BI_W-1:0]  o_bit_index
);

  localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int GD_W = $clog2(GUARD_CYCLES + 1);

  fsk_state_e       r_state, w_state_nxt;
  logic [NBITS-1:0] r_bits;
  logic [15:0]      r_sym;
  logic [3:0]       r_rep;
  logic [15:0]      r_sym_cnt;
  logic [3:0]       r_rep_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic [GD_W-1:0]  r_guard_cnt;
  logic [BI_W-1:0]  r_bit_idx;
  logic             r_pll_888_rst, r_pll_936_rst, r_freq, r_wave, r_lock_err;

  logic w_888_s, w_936_s, w_sel_locked, w_accept;
  logic w_to_hit, w_sym_last, w_guard_last, w_rep_last, w_bit_last, w_next_bit;
  logic [BI_W-1:0] w_bit_idx_dec;

  fsk_pll_scheduler_lock_sync u_sync_888 (
    .clk_12mhz_int (clk_12mhz_int),
    .M_RESET_B     (M_RESET_B),
    .i_async       (i_pll_888_locked),
    .o_sync        (w_888_s)
  );

  fsk_pll_scheduler_lock_sync u_sync_936 (
    .clk_12mhz_int (clk_12mhz_int),
    .M_RESET_B     (M_RESET_B),
    .i_async       (i_pll_936_locked),
    .o_sync        (w_936_s)
  );

  assign w_sel_locked  = r_freq ? w_936_s : w_888_s;
  assign w_accept      = i_frame_valid && (r_state == S_IDLE);
  assign w_to_hit      = (r_to_cnt == TO_W'(LOCK_TIMEOUT - 1));
  assign w_sym_last    = (r_sym_cnt == 16'd0);
  assign w_guard_last  = (r_guard_cnt == '0);
  assign w_rep_last    = (r_rep_cnt == 4'd0);
  assign w_bit_last    = (r_bit_idx == '0);
  assign w_bit_idx_dec = r_bit_idx - BI_W'(1);
  assign w_next_bit    = r_bits[w_bit_idx_dec];

  // State register.
  always_ff @(posedge clk_12mhz_int or negedge M_RESET_B) begin
    if (!M_RESET_B) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state decode; abort overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_accept) w_state_nxt = S_SELECT;
      S_SELECT:    w_state_nxt = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (w_sel_locked)  w_state_nxt = S_EMIT;
        else if (w_to_hit) w_state_nxt = S_IDLE;
      end
      S_EMIT: begin
        if (!w_sel_locked)   w_state_nxt = S_IDLE;
        else if (w_sym_last) w_state_nxt = S_GUARD;
      end
      S_GUARD: begin
        if (w_guard_last) begin
          if (!w_rep_last)               w_state_nxt = S_EMIT;
          else if (w_bit_last)           w_state_nxt = S_FINISH;
          else if (w_next_bit == r_freq) w_state_nxt = S_EMIT;
          else                           w_state_nxt = S_SELECT;
        end
      end
      S_FINISH:    w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
    if (i_abort) w_state_nxt = S_IDLE;
  end

  // Frame capture, counters and registered PLL/antenna controls.
  always_ff @(posedge clk_12mhz_int or negedge M_RESET_B) begin
    if (!M_RESET_B) begin
      r_bits        <= '0;
      r_sym         <= 16'd1;
      r_rep         <= 4'd1;
      r_sym_cnt     <= 16'd0;
      r_rep_cnt     <= 4'd0;
      r_to_cnt      <= '0;
      r_guard_cnt   <= '0;
      r_bit_idx     <= BI_W'(NBITS - 1);
      r_pll_888_rst <= 1'b1;
      r_pll_936_rst <= 1'b1;
      r_freq        <= 1'b0;
      r_wave        <= 1'b0;
      r_lock_err    <= 1'b0;
    end else if (i_abort) begin
      r_wave        <= 1'b0;
      r_pll_888_rst <= 1'b1;
      r_pll_936_rst <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_bits     <= i_frame_bits;
            r_sym      <= min1_16(i_symbol_time);
            r_rep      <= min1_4(i_rep_factor);
            r_rep_cnt  <= min1_4(i_rep_factor) - 4'd1;
            r_bit_idx  <= BI_W'(NBITS - 1);
            r_lock_err <= 1'b0;
          end
        end
        S_SELECT: begin
          // Swap the reset pair in one edge so both are never released.
          r_freq        <= r_bits[r_bit_idx];
          r_pll_888_rst <= r_bits[r_bit_idx];
          r_pll_936_rst <= ~r_bits[r_bit_idx];
          r_to_cnt      <= '0;
        end
        S_WAIT_LOCK: begin
          if (w_sel_locked) begin
            r_wave    <= 1'b1;
            r_sym_cnt <= r_sym - 16'd1;
          end else if (w_to_hit) begin
            r_lock_err    <= 1'b1;
            r_pll_888_rst <= 1'b1;
            r_pll_936_rst <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        S_EMIT: begin
          if (!w_sel_locked) begin
            r_wave        <= 1'b0;
            r_lock_err    <= 1'b1;
            r_pll_888_rst <= 1'b1;
            r_pll_936_rst <= 1'b1;
          end else if (w_sym_last) begin
            r_wave      <= 1'b0;
            r_guard_cnt <= GD_W'(GUARD_CYCLES - 1);
          end else begin
            r_sym_cnt <= r_sym_cnt - 16'd1;
          end
        end
        S_GUARD: begin
          if (!w_guard_last) begin
            r_guard_cnt <= r_guard_cnt - GD_W'(1);
          end else if (!w_rep_last) begin
            r_rep_cnt <= r_rep_cnt - 4'd1;
            r_wave    <= 1'b1;
            r_sym_cnt <= r_sym - 16'd1;
          end else if (w_bit_last) begin
            r_pll_888_rst <= 1'b1;
            r_pll_936_rst <= 1'b1;
          end else begin
            r_bit_idx <= w_bit_idx_dec;
            r_rep_cnt <= r_rep - 4'd1;
            // Same frequency as the running PLL: keep it locked and emit.
            if (w_next_bit == r_freq) begin
              r_wave    <= 1'b1;
              r_sym_cnt <= r_sym - 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_frame_ready = (r_state == S_IDLE);
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = (r_state == S_FINISH);
  assign o_pll_888_rst = r_pll_888_rst;
  assign o_pll_936_rst = r_pll_936_rst;
  assign o_freq_select = r_freq;
  assign o_wave_enable = r_wave;
  assign o_lock_err    = r_lock_err;
  assign o_bit_index   = r_bit_idx;

endmodule

// File: tb/tb_fsk_pll_scheduler.sv
// Directed bench for fsk_pll_scheduler with a simple PLL lock model.
module tb_fsk_pll_scheduler;

  logic         clk_12mhz_int = 1'b0;
  logic         M_RESET_B     = 1'b0;
  logic         frame_valid   = 1'b0;
  logic         frame_ready;
  logic [127:0] frame_bits    = '0;
  logic [15:0]  symbol_time   = '0;
  logic [3:0]   rep_factor    = '0;
  logic         abort         = 1'b0;
  logic         lk888, lk936;
  logic         pll_888_rst, pll_936_rst, freq_select, wave_enable;
  logic         busy, done, lock_err;
  logic [6:0]   bit_index;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_12mhz_int = ~clk_12mhz_int;

  fsk_pll_scheduler dut (
    .clk_12mhz_int    (clk_12mhz_int),
    .M_RESET_B        (M_RESET_B),
    .i_frame_valid    (frame_valid),
    .o_frame_ready    (frame_ready),
    .i_frame_bits     (frame_bits),
    .i_symbol_time    (symbol_time),
    .i_rep_factor     (rep_factor),
    .i_abort          (abort),
    .i_pll_888_locked (lk888),
    .i_pll_936_locked (lk936),
    .o_pll_888_rst    (pll_888_rst),
    .o_pll_936_rst    (pll_936_rst),
    .o_freq_select    (freq_select),
    .o_wave_enable    (wave_enable),
    .o_busy           (busy),
    .o_done           (done),
    .o_lock_err       (lock_err),
    .o_bit_index      (bit_index)
  );

  // PLL model: LOCKED rises lock_dly cycles after release, drops in reset.
  int   lock_dly = 5;
  int   c888 = 0, c936 = 0;
  logic en888 = 1'b1, en936 = 1'b1, drop888 = 1'b0;
  assign lk888 = en888 && (c888 >= lock_dly) && !drop888;
  assign lk936 = en936 && (c936 >= lock_dly);

  always @(negedge clk_12mhz_int) begin
    if (pll_888_rst) c888 = 0; else if (c888 < 1000) c888 = c888 + 1;
    if (pll_936_rst) c936 = 0; else if (c936 < 1000) c936 = c936 + 1;
  end

  // Activity monitor.
  int   pulses, wave_cyc, done_cnt, rel888, rel936, on888, on936, viol, cur_len, min_len, max_len;
  logic p_wave = 1'b0, p888 = 1'b1, p936 = 1'b1;

  always @(negedge clk_12mhz_int) begin
    if (M_RESET_B) begin
      if (wave_enable && !p_wave) begin pulses = pulses + 1; cur_len = 1; end
      else if (wave_enable) cur_len = cur_len + 1;
      if (!wave_enable && p_wave) begin
        if (cur_len < min_len) min_len = cur_len;
        if (cur_len > max_len) max_len = cur_len;
      end
      if (wave_enable) wave_cyc = wave_cyc + 1;
      if (done) done_cnt = done_cnt + 1;
      if (p888 && !pll_888_rst) rel888 = rel888 + 1;
      if (p936 && !pll_936_rst) rel936 = rel936 + 1;
      if (!pll_888_rst) on888 = on888 + 1;
      if (!pll_936_rst) on936 = on936 + 1;
      if (!pll_888_rst && !pll_936_rst) viol = viol + 1;
      if (wave_enable && ((pll_888_rst != p888) || (pll_936_rst != p936))) viol = viol + 1;
    end
    p_wave = wave_enable; p888 = pll_888_rst; p936 = pll_936_rst;
  end

  rst_pair_a: assert property (@(posedge clk_12mhz_int) disable iff (!M_RESET_B)
                               (pll_888_rst || pll_936_rst))
    else $error("FAIL rst_pair: both PLL resets released");

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic clr_mon();
    pulses = 0; wave_cyc = 0; done_cnt = 0; rel888 = 0; rel936 = 0;
    on888 = 0; on936 = 0; viol = 0; cur_len = 0; min_len = 99999; max_len = 0;
  endtask

  task automatic start_frame(input logic [127:0] b, input logic [15:0] s, input logic [3:0] r);
    @(negedge clk_12mhz_int);
    frame_bits = b; symbol_time = s; rep_factor = r; frame_valid = 1'b1;
    @(negedge clk_12mhz_int);
    frame_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n = 0;
    while (busy && n < max) begin @(negedge clk_12mhz_int); n++; end
    chk(tag, busy, 0);
  endtask

  task automatic wait_wave(input logic v, input int max, input string tag);
    int n = 0;
    while (wave_enable !== v && n < max) begin @(negedge clk_12mhz_int); n++; end
    chk(tag, wave_enable, v);
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(negedge clk_12mhz_int);
    abort = 1'b0;
  endtask

  logic [127:0] ones = '1;
  int lat;

  initial begin
    clr_mon();
    repeat (3) @(negedge clk_12mhz_int);
    // Reset values
    chk("rst_ready", frame_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_888", pll_888_rst, 1);
    chk("rst_936", pll_936_rst, 1);
    chk("rst_wave", wave_enable, 0);
    chk("rst_freq", freq_select, 0);
    chk("rst_done", done, 0);
    chk("rst_lerr", lock_err, 0);
    chk("rst_bidx", bit_index, 127);
    M_RESET_B = 1'b1;
    repeat (2) @(negedge clk_12mhz_int);

    // 1: only the LSB set, sym=4, rep=1
    clr_mon();
    start_frame(128'h1, 16'd4, 4'd1);
    chk("t1_busy", busy, 1);
    wait_idle(10000, "t1_idle");
    chk("t1_pulses", pulses, 128);
    chk("t1_wavecyc", wave_cyc, 512);
    chk("t1_minlen", min_len, 4);
    chk("t1_maxlen", max_len, 4);
    chk("t1_done", done_cnt, 1);
    chk("t1_rel888", rel888, 1);
    chk("t1_rel936", rel936, 1);
    chk("t1_lerr", lock_err, 0);
    chk("t1_rsts", {pll_888_rst, pll_936_rst}, 2'b11);
    chk("t1_bidx", bit_index, 0);
    chk("t1_viol", viol, 0);

    // 2: all ones, sym=0, rep=0 -> 1/1
    clr_mon();
    start_frame(ones, 16'd0, 4'd0);
    wait_idle(10000, "t2_idle");
    chk("t2_pulses", pulses, 128);
    chk("t2_wavecyc", wave_cyc, 128);
    chk("t2_maxlen", max_len, 1);
    chk("t2_on888", on888, 0);
    chk("t2_rel936", rel936, 1);
    chk("t2_done", done_cnt, 1);
    chk("t2_viol", viol, 0);

    // 3: 936 never locks -> timeout
    clr_mon();
    en936 = 1'b0;
    start_frame(ones, 16'd4, 4'd1);
    wait_idle(3000, "t3_idle");
    chk("t3_lerr", lock_err, 1);
    chk("t3_rsts", {pll_888_rst, pll_936_rst}, 2'b11);
    chk("t3_waitcyc", on936, 1200);
    chk("t3_done", done_cnt, 0);
    chk("t3_pulses", pulses, 0);
    en936 = 1'b1;

    // 4: lock lost mid-EMIT
    clr_mon();
    start_frame(128'h0, 16'd100, 4'd1);
    chk("t4_lerr_clr", lock_err, 0);
    wait_wave(1'b1, 200, "t4_wave_on");
    repeat (50) @(negedge clk_12mhz_int);
    drop888 = 1'b1;
    lat = 0;
    while (wave_enable && lat < 10) begin @(negedge clk_12mhz_int); lat++; end
    chk("t4_latency_le3", (lat > 0 && lat <= 3), 1);
    chk("t4_lerr", lock_err, 1);
    chk("t4_busy", busy, 0);
    chk("t4_rsts", {pll_888_rst, pll_936_rst}, 2'b11);
    chk("t4_done", done_cnt, 0);
    drop888 = 1'b0;
    repeat (2) @(negedge clk_12mhz_int);

    // 5a: abort mid-GUARD
    clr_mon();
    start_frame(128'h0, 16'd4, 4'd2);
    chk("t5_lerr_clr", lock_err, 0);
    wait_wave(1'b1, 200, "t5_wave_on");
    wait_wave(1'b0, 20, "t5_wave_off");
    repeat (3) @(negedge clk_12mhz_int);
    pulse_abort();
    chk("t5a_busy", busy, 0);
    chk("t5a_wave", wave_enable, 0);
    chk("t5a_rsts", {pll_888_rst, pll_936_rst}, 2'b11);

    // 5b: abort mid-WAIT_LOCK
    lock_dly = 100;
    start_frame(128'h0, 16'd4, 4'd1);
    repeat (20) @(negedge clk_12mhz_int);
    chk("t5b_rst888_rel", pll_888_rst, 0);
    pulse_abort();
    chk("t5b_busy", busy, 0);
    chk("t5b_rsts", {pll_888_rst, pll_936_rst}, 2'b11);
    chk("t5b_ready", frame_ready, 1);
    chk("t5b_done", done_cnt, 0);
    chk("t5b_lerr", lock_err, 0);
    lock_dly = 5;
    clr_mon();
    start_frame(128'h0, 16'd0, 4'd0);
    chk("t5c_busy", busy, 1);
    wait_idle(4000, "t5c_idle");
    chk("t5c_done", done_cnt, 1);
    chk("t5c_pulses", pulses, 128);

    // 6: async reset during EMIT
    start_frame(ones, 16'd50, 4'd1);
    wait_wave(1'b1, 200, "t6_wave_on");
    #3 M_RESET_B = 1'b0;
    #1;
    chk("t6_wave", wave_enable, 0);
    chk("t6_rsts", {pll_888_rst, pll_936_rst}, 2'b11);
    chk("t6_busy", busy, 0);
    chk("t6_freq", freq_select, 0);
    chk("t6_bidx", bit_index, 127);
    @(negedge clk_12mhz_int);
    M_RESET_B = 1'b1;
    repeat (3) @(negedge clk_12mhz_int);
    chk("t6_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
